// File: rtl/lvds_align_pkg.sv
// Shared types and constants for the LVDS word-alignment training logic.
package lvds_align_pkg;

  localparam int unsigned LANE_W = 8;

  localparam logic [LANE_W-1:0] SONY_TRAIN_WORD = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } lane_state_e;

endpackage

// File: rtl/lvds_lane_align.sv
// One lane's alignment FSM: settle, compare against the training word,
// bitslip on mismatch, lock after a run of matches or fail after too many slips.
module lvds_lane_align
  import lvds_align_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MATCH_COUNT   = 4,
  parameter int unsigned MAX_SLIPS     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [LANE_W-1:0] train_pattern,
  input  logic [LANE_W-1:0] lane_word,
  output logic              bitslip,
  output logic              locked,
  output logic              failed
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MATCH_W  = $clog2(MATCH_COUNT + 1);
  localparam int unsigned SLIP_W   = $clog2(MAX_SLIPS + 1);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [SLIP_W-1:0]   SLIP_LIMIT  = SLIP_W'(MAX_SLIPS);

  lane_state_e         state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [MATCH_W-1:0]  match_cnt;
  logic [SLIP_W-1:0]   slip_cnt;

  // Flags are updated alongside the state so they always equal its decode.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      match_cnt  <= '0;
      slip_cnt   <= '0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      failed     <= 1'b0;
    end else begin
      bitslip <= 1'b0;
      case (state)
        ST_IDLE: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
          match_cnt  <= '0;
          slip_cnt   <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (lane_word == train_pattern) begin
            if (match_cnt == MATCH_LAST) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end else begin
            match_cnt <= '0;
            if (slip_cnt == SLIP_LIMIT) begin
              state  <= ST_FAIL;
              failed <= 1'b1;
            end else begin
              state   <= ST_SLIP;
              bitslip <= 1'b1;
            end
          end
        end
        ST_SLIP: begin
          slip_cnt   <= slip_cnt + 1'b1;
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_LOCKED, ST_FAIL: begin
          state <= state;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/lvds_align_ctrl.sv
// Word-alignment training controller: one independent lane FSM per LVDS lane
// plus aligned/error/busy aggregation for the downstream controller.
module lvds_align_ctrl
  import lvds_align_pkg::*;
#(
  parameter int unsigned LANES         = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MATCH_COUNT   = 4,
  parameter int unsigned MAX_SLIPS     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic [LANE_W-1:0]       i_train_pattern,
  input  logic [LANES*LANE_W-1:0] i_lane_data,
  output logic [LANES-1:0]        o_bitslip,
  output logic [LANES-1:0]        o_lane_aligned,
  output logic                    o_aligned,
  output logic                    o_error,
  output logic                    o_busy
);

  logic [LANES-1:0] lane_locked;
  logic [LANES-1:0] lane_failed;
  logic             enable_q;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    lvds_lane_align #(
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .MATCH_COUNT  (MATCH_COUNT),
      .MAX_SLIPS    (MAX_SLIPS)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .enable       (i_enable),
      .train_pattern(i_train_pattern),
      .lane_word    (i_lane_data[n*LANE_W +: LANE_W]),
      .bitslip      (o_bitslip[n]),
      .locked       (lane_locked[n]),
      .failed       (lane_failed[n])
    );
  end

  // enable_q tracks the enable the lane FSMs acted on at the same edge, so
  // busy stays a pure decode of registers with no extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= i_enable;
    end
  end

  always_comb begin
    o_lane_aligned = lane_locked;
    o_aligned      = &lane_locked;
    o_error        = |lane_failed;
    o_busy         = enable_q & ~&(lane_locked | lane_failed);
  end

endmodule

// File: doc/lvds_align_ctrl.md
Name: lvds_align_ctrl

Overview:
Word-alignment training controller for the sensor LVDS receive path. It sits after the 64-bit deserializer-to-lane transpose stage. For each lane, it issues single-cycle bitslip pulses back to the deserializers until the lane's 8-bit word equals the sensor training pattern for a required number of consecutive cycles. It reports per-lane lock, all-lanes aligned, and failure to the downstream controller.

Parameters:
LANES, 8, number of LVDS lanes (one 8-bit word per lane per clock).
SETTLE_CYCLES, 4, wait after each bitslip (and after start) before comparing; range 1..255.
MATCH_COUNT, 4, consecutive matching words required to lock; range 1..255.
MAX_SLIPS, 16, bitslips allowed per lane before declaring failure (two full 8-position passes).

Ports:
clk  input  1  receive-side word clock.
rst  input  1  synchronous, active-high reset.
i_enable  input  1  level; high = train and hold lock, low = return all lanes to idle.
i_train_pattern  input  8  expected training word; must be stable while i_enable is high.
i_lane_data  input  LANES*8  lane n word at [8n+7:8n], same bit order as the transpose stage outputs.
o_bitslip  output  LANES  one-cycle bitslip pulse per lane to the deserializer.
o_lane_aligned  output  LANES  lane n is in LOCKED.
o_aligned  output  1  all lanes are LOCKED.
o_error  output  1  any lane is in FAIL.
o_busy  output  1  i_enable high and not every lane is in LOCKED or FAIL.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. All state and outputs are registered.
- Reset values: all lanes IDLE; all counters 0; o_bitslip, o_lane_aligned, o_aligned, o_error and o_busy all 0.
- Lane FSM states (independent per lane): IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- IDLE: when i_enable=1, go to SETTLE with settle_cnt=0, slip_cnt=0, match_cnt=0.
- SETTLE: stay for exactly SETTLE_CYCLES cycles, counting settle_cnt, then go to CHECK.
- CHECK: compare the lane word against i_train_pattern every cycle.
  - Match with match_cnt==MATCH_COUNT-1: go to LOCKED.
  - Match otherwise: increment match_cnt.
  - Mismatch: clear match_cnt. If slip_cnt==MAX_SLIPS, go to FAIL; otherwise go to SLIP.
- SLIP: o_bitslip[n]=1 for exactly this one cycle; increment slip_cnt; go to SETTLE with settle_cnt=0.
- LOCKED and FAIL: hold until i_enable=0. There is no re-check while locked.
- i_enable=0 in any state: the lane goes to IDLE on the next edge; counters clear; o_bitslip is 0 on that cycle.
- Reset in any state: identical to the i_enable=0 case.
- Timing from i_enable high to first compare: 1 + SETTLE_CYCLES cycles.
- Timing for an already-aligned lane: lock is registered 1 + SETTLE_CYCLES + MATCH_COUNT cycles after i_enable rises.
- Bitslip spacing: consecutive bitslip pulses on one lane are at least SETTLE_CYCLES+2 cycles apart.
- Output derivation:
  - o_lane_aligned[n] = (state==LOCKED).
  - o_aligned = AND of o_lane_aligned.
  - o_error = OR of (state==FAIL).
  - o_busy = i_enable & ~&(locked|fail).
  - All are registered, so they lag the state transition by 0 cycles (they are decoded from state registers, not from next-state logic).
- Counter widths:
  - settle_cnt: $clog2(SETTLE_CYCLES+1).
  - match_cnt: $clog2(MATCH_COUNT+1).
  - slip_cnt: $clog2(MAX_SLIPS+1).
  - No counter wraps; the FSM bounds every count.
- Lanes never interact: one lane's FAIL does not stop the other lanes from training.

Decomposition:
- Shared package lvds_align_pkg holds:
  - the lane state enum;
  - the default training word constant SONY_TRAIN_WORD;
  - a lane word width constant LANE_W=8.
- One sub-module, lvds_lane_align, contains one lane's FSM and counters.
- lvds_align_ctrl instantiates LANES copies of it in a generate loop and performs the AND/OR aggregation.

Test Plan:
Bench setup: SETTLE_CYCLES=4, MATCH_COUNT=4, MAX_SLIPS=16, pattern 8'hA5. The deserializer model rotates a lane's word left by 1 bit on each bitslip.
1. All lanes present 8'hA5; i_enable rises at cycle 0 -> no o_bitslip pulses; o_lane_aligned=8'hFF and o_aligned=1 at cycle 9; o_busy falls at the same time.
2. Lane 3 is offset by 3 slips, the others are aligned -> exactly 3 pulses on o_bitslip[3], each at least 6 cycles apart; lane 3 locks last; o_aligned rises only after lane 3 locks.
3. Lane 5 carries a constant 8'h00 -> exactly 16 bitslip pulses on lane 5, then o_error=1; o_lane_aligned=8'hDF; o_aligned=0; o_busy=0.
4. Lane 1 matches for 2 cycles, mismatches once, then is aligned after 1 slip -> match_cnt clears; exactly one pulse on lane 1; lock follows 4 further consecutive matches.
5. i_enable drops while lane 2 is in SETTLE after 5 slips -> next cycle all outputs are 0; on re-enable, lane 2 restarts with slip_cnt=0 and the first pulse arrives 6 cycles after the rise.
6. rst asserted during SLIP on lane 0 -> that cycle's o_bitslip[0] is the last pulse; after reset all outputs are 0 and the FSM is IDLE regardless of i_enable until rst is released.
